// File: rtl/alu_pkg.sv
// ALU op codes, op legality check and arbiter state type shared by the ALU, decoder and arbiter.
package alu_pkg;
    localparam int NREQ_MAX = 4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;

    typedef enum logic {ST_EMPTY, ST_FULL} arb_state_t;

    function automatic logic alu_op_valid(input logic [3:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT,
            ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_SLL: alu_op_valid = 1'b1;
            default:                                      alu_op_valid = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared ALU arbiter.
interface alu_arbiter_if #(parameter int NREQ = 2);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [4*NREQ-1:0]    req_op;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [31:0]          rsp_result;
    logic                 rsp_zero;
    logic                 rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu.sv
// Combinational RV32 ALU; zero latency, no handshake. Undefined op codes yield 0.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'd0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLL:  result = a << b[4:0];
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set req bit at or above ptr, wrapping modulo NREQ; purely combinational.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_any
);
    int cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = (int'(ptr) + off) % NREQ;
            if (!grant_any && req[cand]) begin
                grant_any       = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = IDXW'(cand);
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters: round-robin accept, one-cycle registered response.
// Response is held until its owner takes it; owner drain and a new accept may share one edge.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   owner;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [31:0]       result_q;
    logic              zero_q;
    logic              err_q;

    logic [NREQ-1:0]   grant;
    logic [IDXW-1:0]   gidx;
    logic              grant_any;
    logic              can_load;
    logic              accept;
    logic [3:0]        sel_op;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic [31:0]       alu_res;
    logic [31:0]       load_res;

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (gidx),
        .grant_any (grant_any)
    );

    assign sel_op = bus.req_op[gidx*4 +: 4];
    assign sel_a  = bus.req_a[gidx*32 +: 32];
    assign sel_b  = bus.req_b[gidx*32 +: 32];

    alu u_alu (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (alu_res)
    );

    assign load_res = alu_op_valid(sel_op) ? alu_res : '0;

    // Only the owner's rsp_ready bit can free the stage.
    assign can_load = (state == ST_EMPTY) || bus.rsp_ready[owner];
    assign accept   = rst_n && can_load && grant_any;

    assign bus.req_ready  = (rst_n && can_load) ? grant : '0;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            ptr         <= '0;
            owner       <= '0;
            rsp_valid_q <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (accept) begin
            state       <= ST_FULL;
            owner       <= gidx;
            rsp_valid_q <= grant;
            result_q    <= load_res;
            zero_q      <= (load_res == 32'd0);
            err_q       <= !alu_op_valid(sel_op);
            if (int'(gidx) == NREQ - 1)
                ptr <= '0;
            else
                ptr <= gidx + 1'b1;
        end else if (state == ST_FULL && bus.rsp_ready[owner]) begin
            state       <= ST_EMPTY;
            rsp_valid_q <= '0;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with NREQ=2: hand-computed vectors checked by immediate assertions.
module tb_alu_arbiter;
    localparam int NREQ = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_arbiter_if #(.NREQ(NREQ)) bus ();

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[i*4 +: 4]  = op;
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] vld, input logic [31:0] res,
                           input logic zero, input logic err);
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(vld));
        chk({tag, ".result"}, bus.rsp_result, res);
        chk({tag, ".zero"}, 32'(bus.rsp_zero), 32'(zero));
        chk({tag, ".err"}, 32'(bus.rsp_err), 32'(err));
    endtask

    logic [1:0]  exp_grant [4];
    logic [31:0] exp_res   [4];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b00;
        bus.req_op = '0;
        bus.req_a  = '0;
        bus.req_b  = '0;
        set_req(0, 4'b0000, 32'd5, 32'd7);

        // Reset state, including req_ready held low while in reset
        repeat (2) @(posedge clk);
        #1;
        chk_rsp("reset", 2'b00, 32'd0, 1'b0, 1'b0);
        chk("reset.req_ready", 32'(bus.req_ready), 32'd0);

        // Single request: ADD 5+7
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("add.req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        chk_rsp("add", 2'b01, 32'd12, 1'b0, 1'b0);

        // Drain req0 and accept req1 SLL 1<<33 on the same edge; ptr 1 -> 0
        @(negedge clk);
        bus.req_valid = 2'b10;
        bus.rsp_ready = 2'b01;
        set_req(1, 4'b1010, 32'd1, 32'd33);
        #1 chk("sll.req_ready", 32'(bus.req_ready), 32'h2);
        @(posedge clk); #1;
        chk_rsp("sll", 2'b10, 32'd2, 1'b0, 1'b0);

        // Contention: grants alternate 0,1,0,1
        exp_grant[0] = 2'b01; exp_res[0] = 32'd0;
        exp_grant[1] = 2'b10; exp_res[1] = 32'hF800_0000;
        exp_grant[2] = 2'b01; exp_res[2] = 32'd0;
        exp_grant[3] = 2'b10; exp_res[3] = 32'hF800_0000;
        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        set_req(0, 4'b0001, 32'd3, 32'd3);
        set_req(1, 4'b1001, 32'h8000_0000, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1 chk($sformatf("rr%0d.req_ready", i), 32'(bus.req_ready), 32'(exp_grant[i]));
            @(posedge clk); #1;
            chk_rsp($sformatf("rr%0d", i), exp_grant[i], exp_res[i], exp_res[i] == 32'd0, 1'b0);
        end

        // Backpressure: owner 1 stalls for 3 cycles; non-owner ready bit ignored
        @(negedge clk);
        bus.req_valid = 2'b01;
        set_req(0, 4'b0111, 32'h0000_F0F0, 32'h0000_0FF0);
        for (int i = 0; i < 3; i++) begin
            bus.rsp_ready = (i == 1) ? 2'b01 : 2'b00;
            #1 chk($sformatf("bp%0d.req_ready", i), 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
            chk_rsp($sformatf("bp%0d", i), 2'b10, 32'hF800_0000, 1'b0, 1'b0);
            @(negedge clk);
        end
        bus.rsp_ready = 2'b10;
        #1 chk("bp_drain.req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        chk_rsp("xor", 2'b01, 32'h0000_FF00, 1'b0, 1'b0);

        // Illegal op on req0 (ptr=1, only req0 valid)
        @(negedge clk);
        bus.rsp_ready = 2'b01;
        set_req(0, 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #1 chk("ill.req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        chk_rsp("ill", 2'b01, 32'd0, 1'b1, 1'b1);

        // Illegal accept advanced ptr to 1: with both valid, req1 wins (SLT -1<1)
        @(negedge clk);
        bus.req_valid = 2'b11;
        set_req(1, 4'b0101, 32'hFFFF_FFFF, 32'd1);
        #1 chk("slt.req_ready", 32'(bus.req_ready), 32'h2);
        @(posedge clk); #1;
        chk_rsp("slt", 2'b10, 32'd1, 1'b0, 1'b0);

        // SLTU 0xFFFFFFFF < 1 -> 0
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b10;
        set_req(0, 4'b0110, 32'hFFFF_FFFF, 32'd1);
        #1 chk("sltu.req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        chk_rsp("sltu", 2'b01, 32'd0, 1'b1, 1'b0);

        // Reset while FULL (ptr=1): cleared without a clock edge
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        rst_n = 1'b0;
        #1;
        chk_rsp("midrst", 2'b00, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 2'b11;
        #1 chk("post_rst.ptr0", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 2'b10;
        set_req(1, 4'b0000, 32'd1, 32'd2);
        #1 chk("post_rst.req_ready", 32'(bus.req_ready), 32'h2);
        @(posedge clk); #1;
        chk_rsp("post_rst", 2'b10, 32'd3, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
